wb_stage: RTL and testbench

//  Writeback stage. It sits directly downstream of the MEM stage and consumes its mem2wb payload.
//  - Aligns and extends load data.
//  - Selects the ALU result or the load result.
//  - Drives the register-file write port one cycle after acceptance.
//  - Publishes a forwarding tap.
//  - Counts retired instructions.
//  - Stalls the pipeline while a load's read data has not yet returned.

---
 rtl/riscv_cpu_pkg.sv | 17 +
 rtl/wb_load_align.sv | 28 ++
 rtl/wb_stage.sv | 144 ++++++++++++++
 tb/tb_wb_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cpu_pkg.sv
// Shared types for the CPU pipeline: writeback load data types and writeback FSM states.
package riscv_cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_BYTE = 2'b00,
        WB_HALF = 2'b01,
        WB_WORD = 2'b10
    } wb_dtype_e;

    typedef enum logic {
        S_IDLE,
        S_WAIT_LOAD
    } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Load data aligner: picks the byte/half lane from a little-endian word and extends it.
module wb_load_align
    import riscv_cpu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      dtype,
    input  logic            sign_ext,
    input  logic [1:0]      lsb,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = data[{lsb, 3'b000} +: 8];
    // lsb[0] is not looked at for halves; misaligned halves never reach this stage
    assign half_lane = lsb[1] ? data[31:16] : data[15:0];

    always_comb begin
        result = data;
        case (dtype)
            WB_BYTE: result = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            WB_HALF: result = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects ALU/load result, drives the registered RF write port and
// forwarding tap, counts retired instructions and stalls while load data is outstanding.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  S_IDLE      | accepting one instruction per cycle from MEM
//  S_WAIT_LOAD | load captured in hold registers, waiting for rvalid
module wb_stage
    import riscv_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int INSTRET_W  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_valid_i,
    input  logic                  wb_rd_we_i,
    input  logic [4:0]            wb_rd_addr_i,
    input  logic                  wb_is_load_i,
    input  logic [1:0]            wb_data_type_i,
    input  logic                  wb_sign_ext_i,
    input  logic [1:0]            wb_addr_lsb_i,
    input  logic [DATA_WIDTH-1:0] wb_alu_result_i,
    input  logic                  wb_mem_valid_i,
    input  logic [DATA_WIDTH-1:0] wb_mem_data_i,
    output logic                  stall_o,
    output logic                  rf_we_o,
    output logic [4:0]            rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  fwd_valid_o,
    output logic [4:0]            fwd_rd_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o,
    output logic [INSTRET_W-1:0]  instret_o
);

    wb_state_e             state_q, state_d;
    logic                  hold_we_q;
    logic [4:0]            hold_rd_q;
    logic [1:0]            hold_type_q;
    logic                  hold_sign_q;
    logic [1:0]            hold_lsb_q;

    logic                  retire, capture, use_alu;
    logic                  sel_we, sel_sign;
    logic [4:0]            sel_rd;
    logic [1:0]            sel_type, sel_lsb;
    logic [DATA_WIDTH-1:0] load_result, result;

    logic                  rf_we_q;
    logic [4:0]            rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;
    logic [INSTRET_W-1:0]  instret_q;

    always_comb begin
        state_d  = state_q;
        stall_o  = 1'b0;
        retire   = 1'b0;
        capture  = 1'b0;
        use_alu  = 1'b0;
        sel_we   = wb_rd_we_i;
        sel_rd   = wb_rd_addr_i;
        sel_type = wb_data_type_i;
        sel_sign = wb_sign_ext_i;
        sel_lsb  = wb_addr_lsb_i;
        case (state_q)
            S_IDLE: begin
                if (wb_valid_i) begin
                    if (!wb_is_load_i) begin
                        retire  = 1'b1;
                        use_alu = 1'b1;
                    end else if (wb_mem_valid_i) begin
                        retire = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        capture = 1'b1;
                        state_d = S_WAIT_LOAD;
                    end
                end
            end
            S_WAIT_LOAD: begin
                // upstream payload is ignored here; the held load owns the port
                sel_we   = hold_we_q;
                sel_rd   = hold_rd_q;
                sel_type = hold_type_q;
                sel_sign = hold_sign_q;
                sel_lsb  = hold_lsb_q;
                if (wb_mem_valid_i) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    wb_load_align u_align (
        .data     (wb_mem_data_i),
        .dtype    (sel_type),
        .sign_ext (sel_sign),
        .lsb      (sel_lsb),
        .result   (load_result)
    );

    assign result = use_alu ? wb_alu_result_i : load_result;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            hold_we_q   <= 1'b0;
            hold_rd_q   <= '0;
            hold_type_q <= '0;
            hold_sign_q <= 1'b0;
            hold_lsb_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            instret_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                hold_we_q   <= wb_rd_we_i;
                hold_rd_q   <= wb_rd_addr_i;
                hold_type_q <= wb_data_type_i;
                hold_sign_q <= wb_sign_ext_i;
                hold_lsb_q  <= wb_addr_lsb_i;
            end
            rf_we_q    <= retire && sel_we && (sel_rd != 5'd0);
            rf_waddr_q <= retire ? sel_rd : 5'd0;
            rf_wdata_q <= retire ? result : '0;
            if (retire) instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign fwd_valid_o = rf_we_q;
    assign fwd_rd_o    = rf_waddr_q;
    assign fwd_data_o  = rf_wdata_q;
    assign instret_o   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; a second instance with a 4-bit counter exercises wrap-around.
module tb_wb_stage;
    import riscv_cpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_valid_i, wb_rd_we_i, wb_is_load_i, wb_sign_ext_i, wb_mem_valid_i;
    logic [4:0]  wb_rd_addr_i;
    logic [1:0]  wb_data_type_i, wb_addr_lsb_i;
    logic [31:0] wb_alu_result_i, wb_mem_data_i;
    logic        stall_o, rf_we_o, fwd_valid_o;
    logic [4:0]  rf_waddr_o, fwd_rd_o;
    logic [31:0] rf_wdata_o, fwd_data_o;
    logic [63:0] instret_o;

    logic        w_stall, w_rf_we, w_fwd_valid;
    logic [4:0]  w_rf_waddr, w_fwd_rd;
    logic [31:0] w_rf_wdata, w_fwd_data;
    logic [3:0]  w_instret;

    int checks = 0;
    int errors = 0;
    int stall_cycles;
    int pulses;

    always #5 clk_i = ~clk_i;

    wb_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .wb_rd_we_i(wb_rd_we_i),
        .wb_rd_addr_i(wb_rd_addr_i), .wb_is_load_i(wb_is_load_i), .wb_data_type_i(wb_data_type_i),
        .wb_sign_ext_i(wb_sign_ext_i), .wb_addr_lsb_i(wb_addr_lsb_i), .wb_alu_result_i(wb_alu_result_i),
        .wb_mem_valid_i(wb_mem_valid_i), .wb_mem_data_i(wb_mem_data_i), .stall_o(stall_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
        .instret_o(instret_o)
    );

    wb_stage #(.INSTRET_W(4)) dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .wb_rd_we_i(wb_rd_we_i),
        .wb_rd_addr_i(wb_rd_addr_i), .wb_is_load_i(wb_is_load_i), .wb_data_type_i(wb_data_type_i),
        .wb_sign_ext_i(wb_sign_ext_i), .wb_addr_lsb_i(wb_addr_lsb_i), .wb_alu_result_i(wb_alu_result_i),
        .wb_mem_valid_i(wb_mem_valid_i), .wb_mem_data_i(wb_mem_data_i), .stall_o(w_stall),
        .rf_we_o(w_rf_we), .rf_waddr_o(w_rf_waddr), .rf_wdata_o(w_rf_wdata),
        .fwd_valid_o(w_fwd_valid), .fwd_rd_o(w_fwd_rd), .fwd_data_o(w_fwd_data),
        .instret_o(w_instret)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wb_valid_i      = 1'b0;
        wb_rd_we_i      = 1'b0;
        wb_rd_addr_i    = 5'd0;
        wb_is_load_i    = 1'b0;
        wb_data_type_i  = 2'b10;
        wb_sign_ext_i   = 1'b0;
        wb_addr_lsb_i   = 2'b00;
        wb_alu_result_i = 32'h0;
        wb_mem_valid_i  = 1'b0;
        wb_mem_data_i   = 32'h0;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] res);
        idle();
        wb_valid_i      = 1'b1;
        wb_rd_we_i      = 1'b1;
        wb_rd_addr_i    = rd;
        wb_alu_result_i = res;
    endtask

    task automatic load_op(input logic [4:0] rd, input logic [1:0] dt, input logic sx,
                           input logic [1:0] lsb, input logic mv, input logic [31:0] md);
        idle();
        wb_valid_i     = 1'b1;
        wb_rd_we_i     = 1'b1;
        wb_rd_addr_i   = rd;
        wb_is_load_i   = 1'b1;
        wb_data_type_i = dt;
        wb_sign_ext_i  = sx;
        wb_addr_lsb_i  = lsb;
        wb_mem_valid_i = mv;
        wb_mem_data_i  = md;
    endtask

    task automatic check_wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_we"}, rf_we_o, 1'b1);
        chk({tag, "_waddr"}, rf_waddr_o, rd);
        chk({tag, "_wdata"}, rf_wdata_o, d);
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_we", rf_we_o, 1'b0);
        chk("rst_waddr", rf_waddr_o, 5'd0);
        chk("rst_wdata", rf_wdata_o, 32'h0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_instret", instret_o, 64'd0);

        // 1: lb sign-extended, data returns with the instruction
        load_op(5'd5, WB_BYTE, 1'b1, 2'd0, 1'b1, 32'h123456F0);
        #1 chk("lb_stall", stall_o, 1'b0);
        @(negedge clk_i);
        check_wr("lb", 5'd5, 32'hFFFFFFF0);
        chk("lb_fwd_valid", fwd_valid_o, 1'b1);
        chk("lb_fwd_rd", fwd_rd_o, 5'd5);
        chk("lb_fwd_data", fwd_data_o, 32'hFFFFFFF0);
        chk("lb_instret", instret_o, 64'd1);

        // 2: lhu then lh at lsb 2, back to back
        load_op(5'd7, WB_HALF, 1'b0, 2'd2, 1'b1, 32'h8001ABCD);
        @(negedge clk_i);
        check_wr("lhu", 5'd7, 32'h00008001);
        load_op(5'd7, WB_HALF, 1'b1, 2'd2, 1'b1, 32'h8001ABCD);
        @(negedge clk_i);
        check_wr("lh", 5'd7, 32'hFFFF8001);
        chk("lh_instret", instret_o, 64'd3);

        // 3: lw, rvalid late; upstream churns during the stall
        load_op(5'd3, WB_WORD, 1'b0, 2'd0, 1'b0, 32'h0);
        stall_cycles = 0;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            #1 if (stall_o) stall_cycles++;
            @(negedge clk_i);
            if (rf_we_o) pulses++;
            alu_op(5'd9, 32'h11110000 + c);
        end
        wb_mem_valid_i = 1'b1;
        wb_mem_data_i  = 32'hCAFEF00D;
        #1 chk("lw_stall_drop", stall_o, 1'b0);
        chk("lw_stall_cycles", stall_cycles, 3);
        chk("lw_no_early_we", pulses, 0);
        @(negedge clk_i);
        check_wr("lw", 5'd3, 32'hCAFEF00D);
        chk("lw_instret", instret_o, 64'd4);
        idle();
        @(negedge clk_i);
        chk("lw_single_pulse", rf_we_o, 1'b0);
        chk("lw_instret_hold", instret_o, 64'd4);

        // 4: write to x0 is suppressed but retires
        alu_op(5'd0, 32'hDEADBEEF);
        @(negedge clk_i);
        chk("x0_we", rf_we_o, 1'b0);
        chk("x0_instret", instret_o, 64'd5);

        // 5: ten back-to-back ALU ops
        pulses = 0;
        stall_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            alu_op(5'(i + 1), 32'h1000 + i);
            #1 if (stall_o) stall_cycles++;
            @(negedge clk_i);
            if (rf_we_o && rf_waddr_o == 5'(i + 1) && rf_wdata_o == 32'h1000 + i) pulses++;
        end
        idle();
        chk("b2b_pulses", pulses, 10);
        chk("b2b_stalls", stall_cycles, 0);
        chk("b2b_instret", instret_o, 64'd15);
        chk("wrap_pre", w_instret, 4'hF);
        alu_op(5'd1, 32'h1);
        @(negedge clk_i);
        idle();
        chk("wrap_post", w_instret, 4'h0);
        chk("wrap_main", instret_o, 64'd16);

        // 6: reset while waiting for load data
        load_op(5'd4, WB_WORD, 1'b0, 2'd0, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("rstw_stall", stall_o, 1'b1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        idle();
        wb_mem_valid_i = 1'b1;
        wb_mem_data_i  = 32'h55AA55AA;
        #1;
        chk("rstw_stall_after", stall_o, 1'b0);
        chk("rstw_instret", instret_o, 64'd0);
        chk("rstw_state", dut.state_q, S_IDLE);
        chk("rstw_we_after_rst", rf_we_o, 1'b0);
        @(negedge clk_i);
        idle();
        chk("rstw_no_we", rf_we_o, 1'b0);
        chk("rstw_instret2", instret_o, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
